// File: rtl/traffic_phase_ctrl.sv
// Traffic intersection phase controller: green/yellow/all-red rotation over NUM_DIR approaches,
// latched pedestrian service, night flashing mode, and a BCD countdown of the seconds left.
module traffic_phase_ctrl #(
  parameter int TICK_CYC = 100000000,
  parameter int NUM_DIR  = 2,
  parameter int GREEN_S  = 4,
  parameter int YELLOW_S = 2,
  parameter int ALLRED_S = 1,
  parameter int PED_S    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ped_req,
  input  logic               night,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic               walk,
  output logic [1:0]         dir_idx,
  output logic [7:0]         remain_bcd,
  output logic               phase_start,
  output logic [2:0]         state
);

  if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_bad_num_dir
    $error("traffic_phase_ctrl: NUM_DIR must be 2..4");
  end
  if (GREEN_S < 1 || GREEN_S > 99 || YELLOW_S < 1 || YELLOW_S > 99 ||
      ALLRED_S < 1 || ALLRED_S > 99 || PED_S < 1 || PED_S > 99) begin : g_bad_duration
    $error("traffic_phase_ctrl: durations must be 1..99");
  end
  if (TICK_CYC < 1) begin : g_bad_tick
    $error("traffic_phase_ctrl: TICK_CYC must be at least 1");
  end

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYC - 1);
  localparam logic [7:0] ALLRED_BCD = 8'(((ALLRED_S / 10) << 4) | (ALLRED_S % 10));

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_PED    = 3'd3,
    S_FLASH  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         dir_q, dir_d, dir_next;
  logic [6:0]         remain_q, remain_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               ped_l_q, ped_l_d;
  logic               night_l_q, night_l_d;
  logic               flash_y_q, flash_y_d;
  logic               first_q;
  logic [NUM_DIR-1:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;
  logic               walk_q, walk_d;
  logic               phase_start_q, phase_start_d;
  logic [7:0]         remain_bcd_q, remain_bcd_d;
  logic               tick, entry;
  logic [NUM_DIR-1:0] dir_mask, all_dirs;
  logic [7:0]         rem8;

  function automatic logic [6:0] phase_dur(state_e s);
    case (s)
      S_GREEN:  return 7'(GREEN_S);
      S_YELLOW: return 7'(YELLOW_S);
      S_ALLRED: return 7'(ALLRED_S);
      S_PED:    return 7'(PED_S);
      default:  return 7'd0;
    endcase
  endfunction

  always_comb begin
    tick     = (presc_q == TICK_LAST);
    dir_next = (dir_q == 2'(NUM_DIR - 1)) ? 2'd0 : dir_q + 2'd1;
    state_d  = state_q;
    dir_d    = dir_q;
    remain_d = remain_q;
    flash_y_d = flash_y_q;
    entry    = 1'b0;

    case (state_q)
      S_GREEN, S_YELLOW, S_ALLRED, S_PED: begin
        if (tick) begin
          if (remain_q == 7'd1) begin
            entry = 1'b1;
            case (state_q)
              S_GREEN:  state_d = S_YELLOW;
              S_YELLOW: begin
                state_d = S_ALLRED;
                dir_d   = dir_next;
              end
              S_ALLRED: state_d = night_l_q ? S_FLASH : (ped_l_q ? S_PED : S_GREEN);
              default:  state_d = S_GREEN;
            endcase
          end else begin
            remain_d = remain_q - 7'd1;
          end
        end
      end
      S_FLASH: begin
        if (tick) begin
          if (night_l_q) flash_y_d = ~flash_y_q;
          else begin
            state_d = S_ALLRED;
            entry   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_ALLRED;
        entry   = 1'b1;
      end
    endcase

    // The first cycle out of reset re-enters ALLRED so it gets a full, announced phase.
    if (first_q) begin
      state_d = S_ALLRED;
      dir_d   = dir_q;
      entry   = 1'b1;
    end

    if (entry) begin
      presc_d   = '0;
      remain_d  = phase_dur(state_d);
      flash_y_d = 1'b1;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    ped_l_d       = ped_req | (ped_l_q & ~(entry & (state_d == S_PED)));
    night_l_d     = night;
    phase_start_d = entry;

    dir_mask = {{(NUM_DIR-1){1'b0}}, 1'b1} << dir_d;
    all_dirs = '1;
    green_d  = '0;
    yellow_d = '0;
    red_d    = all_dirs;
    walk_d   = 1'b0;
    case (state_d)
      S_GREEN: begin
        green_d = dir_mask;
        red_d   = ~dir_mask;
      end
      S_YELLOW: begin
        yellow_d = dir_mask;
        red_d    = ~dir_mask;
      end
      S_PED:   walk_d = 1'b1;
      S_FLASH: begin
        red_d    = '0;
        yellow_d = flash_y_d ? all_dirs : '0;
      end
      default: ;
    endcase

    rem8         = {1'b0, remain_d};
    remain_bcd_d = {4'(rem8 / 8'd10), 4'(rem8 % 8'd10)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_ALLRED;
      dir_q         <= 2'd0;
      remain_q      <= 7'(ALLRED_S);
      presc_q       <= '0;
      ped_l_q       <= 1'b0;
      night_l_q     <= 1'b0;
      flash_y_q     <= 1'b0;
      first_q       <= 1'b1;
      green_q       <= '0;
      yellow_q      <= '0;
      red_q         <= '1;
      walk_q        <= 1'b0;
      phase_start_q <= 1'b0;
      remain_bcd_q  <= ALLRED_BCD;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      remain_q      <= remain_d;
      presc_q       <= presc_d;
      ped_l_q       <= ped_l_d;
      night_l_q     <= night_l_d;
      flash_y_q     <= flash_y_d;
      first_q       <= 1'b0;
      green_q       <= green_d;
      yellow_q      <= yellow_d;
      red_q         <= red_d;
      walk_q        <= walk_d;
      phase_start_q <= phase_start_d;
      remain_bcd_q  <= remain_bcd_d;
    end
  end

  assign green       = green_q;
  assign yellow      = yellow_q;
  assign red         = red_q;
  assign walk        = walk_q;
  assign dir_idx     = dir_q;
  assign remain_bcd  = remain_bcd_q;
  assign phase_start = phase_start_q;
  assign state       = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl: two configurations driven in parallel and compared
// every cycle against a phase-time reference model (cycles left in phase, not prescaler/remain).
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  logic reset, ped_req, night;
  always #5 clk = ~clk;

  logic [1:0] g_a, y_a, r_a;
  logic [3:0] g_b, y_b, r_b;
  logic       w_a, w_b, ps_a, ps_b;
  logic [1:0] di_a, di_b;
  logic [7:0] bcd_a, bcd_b;
  logic [2:0] st_a, st_b;

  traffic_phase_ctrl #(.TICK_CYC(10), .NUM_DIR(2), .GREEN_S(4), .YELLOW_S(2), .ALLRED_S(1), .PED_S(5)) dut_a (
    .clk(clk), .reset(reset), .ped_req(ped_req), .night(night),
    .green(g_a), .yellow(y_a), .red(r_a), .walk(w_a), .dir_idx(di_a),
    .remain_bcd(bcd_a), .phase_start(ps_a), .state(st_a));

  traffic_phase_ctrl #(.TICK_CYC(3), .NUM_DIR(4), .GREEN_S(12), .YELLOW_S(1), .ALLRED_S(1), .PED_S(1)) dut_b (
    .clk(clk), .reset(reset), .ped_req(ped_req), .night(night),
    .green(g_b), .yellow(y_b), .red(r_b), .walk(w_b), .dir_idx(di_b),
    .remain_bcd(bcd_b), .phase_start(ps_b), .state(st_b));

  localparam int ALLRED = 0, GREEN = 1, YELLOW = 2, PED = 3, FLASH = 4;

  int tk[2], nd[2], dur[2][5];
  int ms[2], md[2], mleft[2];
  bit mped[2], mnight[2], mfy[2], mps[2], mfirst[2];
  int n_checks = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(int i, bit rst, bit pr, bit nt);
    int nxt;
    bit entered;
    if (rst) begin
      ms[i] = ALLRED; md[i] = 0; mleft[i] = dur[i][ALLRED] * tk[i];
      mped[i] = 0; mnight[i] = 0; mfy[i] = 0; mps[i] = 0; mfirst[i] = 1;
      return;
    end
    entered = 0;
    nxt = ms[i];
    if (mfirst[i]) begin
      entered = 1; nxt = ALLRED; mfirst[i] = 0;
    end else begin
      mleft[i]--;
      if (mleft[i] == 0) begin
        case (ms[i])
          GREEN:  begin nxt = YELLOW; entered = 1; end
          YELLOW: begin nxt = ALLRED; entered = 1; md[i] = (md[i] + 1) % nd[i]; end
          ALLRED: begin nxt = mnight[i] ? FLASH : (mped[i] ? PED : GREEN); entered = 1; end
          PED:    begin nxt = GREEN; entered = 1; end
          default: begin
            if (mnight[i]) begin mfy[i] = !mfy[i]; mleft[i] = tk[i]; end
            else begin nxt = ALLRED; entered = 1; end
          end
        endcase
      end
    end
    if (entered) begin
      ms[i] = nxt;
      mleft[i] = (nxt == FLASH) ? tk[i] : dur[i][nxt] * tk[i];
      if (nxt == FLASH) mfy[i] = 1;
    end
    mps[i] = entered;
    mped[i] = pr | (mped[i] & !(entered && nxt == PED));
    mnight[i] = nt;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i, reset, ped_req, night);
  end

  task automatic check_inst(int i, logic [3:0] g, logic [3:0] y, logic [3:0] r, logic w,
                            logic [1:0] di, logic [7:0] bcd, logic ps, logic [2:0] st);
    logic [3:0] mask, dm, eg, ey, er;
    int rem, s;
    mask = 4'((1 << nd[i]) - 1);
    dm = 4'(1 << md[i]);
    eg = 0; ey = 0; er = mask;
    case (ms[i])
      GREEN:  begin eg = dm; er = mask & ~dm; end
      YELLOW: begin ey = dm; er = mask & ~dm; end
      FLASH:  begin er = 0; ey = mfy[i] ? mask : 4'h0; end
      default: ;
    endcase
    rem = (ms[i] == FLASH) ? 0 : (mleft[i] + tk[i] - 1) / tk[i];
    chk(i ? "b_state" : "a_state", 32'(st), 32'(ms[i]));
    chk(i ? "b_dir" : "a_dir", 32'(di), 32'(md[i]));
    chk(i ? "b_green" : "a_green", 32'(g), 32'(eg));
    chk(i ? "b_yellow" : "a_yellow", 32'(y), 32'(ey));
    chk(i ? "b_red" : "a_red", 32'(r), 32'(er));
    chk(i ? "b_walk" : "a_walk", 32'(w), 32'(ms[i] == PED));
    chk(i ? "b_phase_start" : "a_phase_start", 32'(ps), 32'(mps[i]));
    chk(i ? "b_remain_bcd" : "a_remain_bcd", 32'(bcd), 32'((rem / 10) * 16 + rem % 10));
    if (st != 3'(FLASH)) begin
      for (int d = 0; d < nd[i]; d++) begin
        s = 0;
        s += int'(g[d]); s += int'(y[d]); s += int'(r[d]);
        chk(i ? "b_one_lamp" : "a_one_lamp", 32'(s), 32'd1);
      end
    end
  endtask

  initial begin
    bit yrst_done = 0;
    tk[0] = 10; nd[0] = 2;
    dur[0][ALLRED] = 1; dur[0][GREEN] = 4; dur[0][YELLOW] = 2; dur[0][PED] = 5; dur[0][FLASH] = 0;
    tk[1] = 3;  nd[1] = 4;
    dur[1][ALLRED] = 1; dur[1][GREEN] = 12; dur[1][YELLOW] = 1; dur[1][PED] = 1; dur[1][FLASH] = 0;
    reset = 1; ped_req = 0; night = 0;
    repeat (3) @(negedge clk);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (cyc > 0) begin
        check_inst(0, {2'b00, g_a}, {2'b00, y_a}, {2'b00, r_a}, w_a, di_a, bcd_a, ps_a, st_a);
        check_inst(1, g_b, y_b, r_b, w_b, di_b, bcd_b, ps_b, st_b);
      end
      reset = 0; ped_req = 0;
      if (cyc >= 400) begin
        ped_req = ($urandom_range(0, 79) == 0);
        if (!night && $urandom_range(0, 1499) == 0) night = 1;
        else if (night && $urandom_range(0, 199) == 0) night = 0;
        reset = ($urandom_range(0, 2999) == 0);
        // Land a request exactly on the PED-entry edge so the set-wins rule is exercised.
        if (ms[0] == ALLRED && mleft[0] == 1 && !mnight[0] && mped[0] && $urandom_range(0, 1) == 1)
          ped_req = 1;
        if (!yrst_done && cyc > 3000 && ms[0] == YELLOW && mleft[0] == 1) begin
          reset = 1; yrst_done = 1;
        end
      end
      @(negedge clk);
    end
    chk("yellow_reset_hit", 32'(yrst_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 The block SHALL use one clock, clk, with reset as a synchronous, active-high reset named reset.
REQ-002 Parameters SHALL be as follows, given as name, default, meaning:
- TICK_CYC, 100000000, clk cycles per 1 s tick.
- NUM_DIR, 2, approach groups, legal range 2..4.
- GREEN_S, 4, green seconds.
- YELLOW_S, 2, yellow seconds.
- ALLRED_S, 1, all-red clearance seconds.
- PED_S, 5, pedestrian walk seconds.
- All durations SHALL be in the range 1..99; elaboration SHALL fail outside it.
REQ-003 Ports SHALL be as follows, given as name, direction, width, meaning:
- clk, in, 1, clock.
- reset, in, 1, sync active-high reset.
- ped_req, in, 1, pedestrian request, level or pulse.
- night, in, 1, flashing-mode request.
- green, out, NUM_DIR, per-direction green.
- yellow, out, NUM_DIR, per-direction yellow.
- red, out, NUM_DIR, per-direction red.
- walk, out, 1, pedestrian walk lamp.
- dir_idx, out, 2, current or next served direction.
- remain_bcd, out, 8, seconds left in phase, two BCD digits, tens in [7:4].
- phase_start, out, 1, one-cycle pulse on every state entry.
- state, out, 3, FSM state code.
- All outputs SHALL be registered.

Function
REQ-004 A prescaler SHALL count 0..TICK_CYC-1 and assert tick for exactly one cycle when it wraps.
REQ-005 The prescaler SHALL restart at 0 on every state entry, so each phase lasts exactly duration*TICK_CYC cycles.
REQ-006 The FSM states SHALL be encoded as ALLRED=0, GREEN=1, YELLOW=2, PED=3, FLASH=4; codes 5..7 SHALL go to ALLRED on the next cycle.
REQ-007 On state entry, remain SHALL load that state's duration and phase_start SHALL pulse.
REQ-008 On each tick, if remain==1 the FSM SHALL take its transition; otherwise remain SHALL decrement.
REQ-009 In FLASH, remain SHALL hold 0.
REQ-010 Transitions:
- GREEN -> YELLOW.
- YELLOW -> ALLRED, and dir_idx SHALL advance (NUM_DIR-1 wraps to 0).
- ALLRED expiry with night_l=1 -> FLASH.
- ALLRED expiry with night_l=0 and ped_l=1 -> PED.
- ALLRED expiry otherwise -> GREEN.
- PED -> GREEN, with dir_idx unchanged.
- FLASH: on the first tick with night_l=0 -> ALLRED.
REQ-011 Lamps per state:
- GREEN: green[dir_idx]=1 and all other directions red.
- YELLOW: yellow[dir_idx]=1 and all other directions red.
- ALLRED and PED: all red; walk=1 only in PED.
- FLASH: red=0, green=0, walk=0, and all yellow bits toggle on each tick, starting at 1 on entry.
REQ-012 Per direction, exactly one of green, yellow or red SHALL be set, except in FLASH.
REQ-013 ped_l SHALL be set on any cycle with ped_req=1 and cleared on PED entry; set SHALL win if both occur in the same cycle.
REQ-014 A ped_req arriving during PED SHALL therefore be served after the next ALLRED.
REQ-015 night_l SHALL be a registered copy of night, sampled every cycle; its effect is decided only at ALLRED expiry or at a FLASH tick.
REQ-016 Night SHALL take priority over a pending pedestrian request; ped_l SHALL stay latched through FLASH.
REQ-017 remain_bcd SHALL equal the binary remain converted to BCD and update in the same cycle as remain, with no extra latency.
REQ-018 A duration of 1 SHALL give a single-tick phase, with remain_bcd=0x01 for the whole phase.

Reset
REQ-019 While reset=1 the registers SHALL take these values: state=ALLRED, dir_idx=0, remain=ALLRED_S, prescaler=0, ped_l=0, night_l=0.
REQ-020 While reset=1 the outputs SHALL be: green=0, yellow=0, red=all ones, walk=0, phase_start=0.
REQ-021 The first cycle after reset is released SHALL pulse phase_start, and the controller SHALL then run a full ALLRED phase before GREEN for dir 0.
REQ-022 Reset asserted mid-phase SHALL override any same-cycle tick or transition and discard ped_l and night_l.

Verification
REQ-023 Normal cycle: TICK_CYC=10, NUM_DIR=2, defaults, no inputs.
- Required sequence: ALLRED 10 cycles, then G0 40, Y0 20, ALLRED 10, G1 40, Y1 20, ALLRED, then G0.
- remain_bcd during G0 SHALL read 4, 3, 2, 1.
REQ-024 Pedestrian: a 1-cycle ped_req during G0.
- Required sequence: Y0, ALLRED, PED with walk=1 for 50 cycles and remain_bcd 5..1, then G1.
- A second ped_req during PED SHALL produce another PED after Y1's ALLRED.
REQ-025 Night: night=1 raised during G1.
- Required sequence: Y1, ALLRED, FLASH with yellow=2'b11 and 2'b00 alternating every 10 cycles, red=0.
- When night drops, the next tick SHALL go to ALLRED and then G0.
REQ-026 Simultaneous events: ped_req=1 and night=1 both pending at ALLRED expiry.
- FLASH SHALL be entered first; after night clears, ALLRED then PED SHALL follow.
- ped_req on the PED-entry cycle SHALL leave ped_l=1.
REQ-027 Generality: NUM_DIR=4 and GREEN_S=12.
- Directions SHALL be served 0,1,2,3,0.
- remain_bcd SHALL read 0x12, 0x11, 0x10, 0x09 at the start of green.
REQ-028 Reset mid-YELLOW with tick coincident: outputs SHALL equal the REQ-019 and REQ-020 values on the next cycle, with dir_idx=0.
REQ-029 Assertions SHALL check REQ-012 every cycle, and check phase_start as exactly one pulse per state change.
